// File: rtl/unified_memory_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch (IF) and data memory (MEM).
// Data wins by default; a starvation counter forces an IF grant after STARVE_LIMIT denials.
module unified_memory_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              pc_reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              stall_if,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_valid,
  output logic              stall_mem,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              proto_err
);

  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_RD, MEM_WR} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state;
  state_t            state_next;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] if_hold;
  logic [DATA_W-1:0] mem_hold;
  logic              mem_req;
  logic              grant_if;
  logic              grant_mem;

  always_comb begin
    mem_req    = 1'b0;
    grant_if   = 1'b0;
    grant_mem  = 1'b0;
    state_next = IDLE;
    stall_if   = 1'b0;
    stall_mem  = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if_valid   = 1'b0;
    if_rdata   = '0;
    mem_valid  = 1'b0;
    mem_rdata  = '0;

    if (!pc_reset) begin
      mem_req   = mem_rd | mem_wr;
      grant_if  = if_req & (~mem_req | (starve_cnt == LIMIT));
      grant_mem = mem_req & ~grant_if;
      stall_if  = if_req & ~grant_if;
      stall_mem = mem_req & ~grant_mem;

      if (grant_if) begin
        state_next = IF_ACC;
        sram_addr  = if_addr;
      end else if (grant_mem) begin
        state_next = mem_wr ? MEM_WR : MEM_RD;
        sram_addr  = mem_addr;
      end

      sram_en    = grant_if | grant_mem;
      sram_we    = grant_mem & mem_wr;
      sram_wdata = sram_en ? mem_wdata : '0;

      // The SRAM answers one cycle after the grant, so the response is decoded from the last grant.
      if_valid  = (state == IF_ACC);
      mem_valid = (state == MEM_RD) || (state == MEM_WR);
      if_rdata  = (state == IF_ACC) ? sram_rdata : if_hold;
      mem_rdata = (state == MEM_RD) ? sram_rdata : mem_hold;
    end
  end

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      if_hold    <= '0;
      mem_hold   <= '0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IF_ACC) if_hold <= sram_rdata;
      if (state == MEM_RD) mem_hold <= sram_rdata;
      if (mem_rd && mem_wr) proto_err <= 1'b1;
      if (stall_if)
        starve_cnt <= (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 4'd1;
      else if (grant_if)
        starve_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Self-checking bench for unified_memory_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model with its own shadow memory.
module tb_unified_memory_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          pc_reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          stall_if;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;
  logic          stall_mem;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic          proto_err;

  always #5 clk = ~clk;

  unified_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .pc_reset(pc_reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .stall_if(stall_if),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .stall_mem(stall_mem),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .proto_err(proto_err)
  );

  // Behavioural single-port synchronous SRAM macro.
  logic [DW-1:0] sram [0:65535];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram[sram_addr] <= sram_wdata;
      else         sram_rdata      <= sram[sram_addr];
    end
  end

  // Reference model: shadow memory, denial counter, and the one response owed next cycle.
  logic [DW-1:0] shadow [0:65535];
  int            starve;
  int            pend_kind;
  logic [DW-1:0] pend_data;
  logic [DW-1:0] held_if;
  logic [DW-1:0] held_mem;
  bit            proto;
  int            checks = 0;
  int            errors = 0;
  logic [8:0]    stall_seen;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " sram_en"}, 32'(sram_en), 0);
    checkOutput({tag, " sram_we"}, 32'(sram_we), 0);
    checkOutput({tag, " sram_addr"}, 32'(sram_addr), 0);
    checkOutput({tag, " sram_wdata"}, 32'(sram_wdata), 0);
    checkOutput({tag, " stall_if"}, 32'(stall_if), 0);
    checkOutput({tag, " stall_mem"}, 32'(stall_mem), 0);
    checkOutput({tag, " if_valid"}, 32'(if_valid), 0);
    checkOutput({tag, " mem_valid"}, 32'(mem_valid), 0);
    checkOutput({tag, " if_rdata"}, 32'(if_rdata), 0);
    checkOutput({tag, " mem_rdata"}, 32'(mem_rdata), 0);
    checkOutput({tag, " proto_err"}, 32'(proto_err), 0);
  endtask

  task automatic resetModel();
    starve    = 0;
    pend_kind = 0;
    pend_data = '0;
    held_if   = '0;
    held_mem  = '0;
    proto     = 0;
  endtask

  // One clock cycle: drive the requests, check every output mid-cycle, advance the model.
  task automatic applyStimulus(input logic ireq, input logic [AW-1:0] iaddr, input logic rd,
                               input logic wr, input logic [AW-1:0] maddr, input logic [DW-1:0] wd);
    bit            mreq;
    bit            gif;
    bit            gmem;
    logic [AW-1:0] eaddr;
    @(posedge clk);
    #1;
    if_req = ireq; if_addr = iaddr; mem_rd = rd; mem_wr = wr; mem_addr = maddr; mem_wdata = wd;
    @(negedge clk);
    mreq  = rd || wr;
    gif   = ireq && (!mreq || starve == LIMIT);
    gmem  = mreq && !gif;
    eaddr = gif ? iaddr : (gmem ? maddr : '0);
    checkOutput("stall_if", 32'(stall_if), 32'(ireq && !gif));
    checkOutput("stall_mem", 32'(stall_mem), 32'(mreq && !gmem));
    checkOutput("sram_en", 32'(sram_en), 32'(gif || gmem));
    checkOutput("sram_we", 32'(sram_we), 32'(gmem && wr));
    checkOutput("sram_addr", 32'(sram_addr), 32'(eaddr));
    checkOutput("sram_wdata", 32'(sram_wdata), (gif || gmem) ? 32'(wd) : 0);
    checkOutput("if_valid", 32'(if_valid), 32'(pend_kind == 1));
    checkOutput("if_rdata", 32'(if_rdata), 32'((pend_kind == 1) ? pend_data : held_if));
    checkOutput("mem_valid", 32'(mem_valid), 32'(pend_kind == 2 || pend_kind == 3));
    checkOutput("mem_rdata", 32'(mem_rdata), 32'((pend_kind == 2) ? pend_data : held_mem));
    checkOutput("proto_err", 32'(proto_err), 32'(proto));

    if (pend_kind == 1) held_if = pend_data;
    if (pend_kind == 2) held_mem = pend_data;
    if (rd && wr) proto = 1;
    if (ireq && !gif) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
    else if (gif)     starve = 0;
    if (gif) begin
      pend_kind = 1; pend_data = shadow[iaddr];
    end else if (gmem && wr) begin
      pend_kind = 3; shadow[maddr] = wd;
    end else if (gmem) begin
      pend_kind = 2; pend_data = shadow[maddr];
    end else begin
      pend_kind = 0;
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) begin
      sram[a]   = 16'(a * 7 + 3);
      shadow[a] = 16'(a * 7 + 3);
    end
    for (int a = 0; a < 4; a++) begin
      sram[a]   = 16'hA001 + 16'(a);
      shadow[a] = 16'hA001 + 16'(a);
    end
    sram[16'h0200]   = 16'h1234;
    shadow[16'h0200] = 16'h1234;
    resetModel();

    // Power-on reset with every request asserted: all outputs must stay low.
    pc_reset = 1'b1;
    if_req = 1'b1; if_addr = 16'h0001; mem_rd = 1'b1; mem_wr = 1'b1;
    mem_addr = 16'h0002; mem_wdata = 16'h7777;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("por");
    @(posedge clk);
    #1;
    pc_reset = 1'b0;
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;

    // IF alone streams one fetch per cycle.
    for (int i = 0; i < 4; i++) applyStimulus(1, 16'(i), 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t1 last fetch", 32'(if_rdata), 32'h0000A004);

    // Collision: data wins, fetch follows.
    applyStimulus(1, 16'h0010, 1, 0, 16'h0200, 0);
    applyStimulus(1, 16'h0010, 0, 0, 0, 0);
    checkOutput("t2 mem_rdata", 32'(mem_rdata), 32'h00001234);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Sustained writes starve IF until the forced grant in the fifth cycle.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 16'h0010, 0, 1, 16'h0310, 16'(i));
      stall_seen[i] = stall_if;
    end
    checkOutput("t3 stall pattern", 32'(stall_seen), 32'h000001EF);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Write then read back through the data port.
    applyStimulus(0, 0, 0, 1, 16'h0300, 16'hBEEF);
    applyStimulus(0, 0, 1, 0, 16'h0300, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4 readback", 32'(mem_rdata), 32'h0000BEEF);
    applyStimulus(0, 0, 0, 1, 16'h0301, 16'h1111);
    applyStimulus(0, 0, 0, 0, 0, 0);

    // Random traffic over a small address window to force collisions and reuse.
    for (int i = 0; i < 300; i++) begin
      int op;
      op = int'($urandom_range(0, 9));
      applyStimulus(($urandom_range(0, 9) < 7), 16'($urandom_range(0, 15)),
                    (op < 3), (op >= 3 && op < 6), 16'($urandom_range(0, 15)), 16'($urandom));
    end

    // Simultaneous read and write is a write and raises a sticky error.
    applyStimulus(0, 0, 1, 1, 16'h0040, 16'h5555);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 16'h0040, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t5 proto sticky", 32'(proto_err), 1);
    checkOutput("t5 written data", 32'(mem_rdata), 32'h00005555);

    // Reset arriving between an IF grant and its response drops the response.
    applyStimulus(1, 16'h0002, 0, 0, 0, 0);
    pc_reset = 1'b1;
    #1;
    checkReset("rst async");
    @(posedge clk);
    #1;
    checkReset("rst held");
    @(posedge clk);
    #1;
    pc_reset = 1'b0;
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    resetModel();
    applyStimulus(1, 16'h0003, 0, 0, 0, 0);
    applyStimulus(1, 16'h0001, 1, 0, 16'h0200, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
